// File: rtl/cpu64_l3_pkg.sv
// Shared types and bus widths for the L3 port arbiter: arbiter and
// invalidate state encodings, OBI field widths and an index-width helper.
package cpu64_l3_pkg;

  localparam int unsigned BE_W   = 8;
  localparam int unsigned ADDR_W = 64;
  localparam int unsigned DATA_W = 64;

  typedef enum logic [0:0] {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_e;

  typedef enum logic [0:0] {
    INV_IDLE = 1'b0,
    INV_DONE = 1'b1
  } inv_state_e;

  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 32'd1) ? int'($clog2(n)) : 32'd1;
  endfunction

endpackage

// File: rtl/cpu64_l3_port_arbiter_if.sv
// Bundle of upstream L2, downstream L3 and back-invalidate signals.
// slave = arbiter side, master = environment side.
interface cpu64_l3_port_arbiter_if #(
  parameter int unsigned N_PORTS = 2
);
  import cpu64_l3_pkg::*;

  logic [N_PORTS-1:0]        s_req_i;
  logic [N_PORTS-1:0]        s_we_i;
  logic [N_PORTS*BE_W-1:0]   s_be_i;
  logic [N_PORTS*ADDR_W-1:0] s_addr_i;
  logic [N_PORTS*DATA_W-1:0] s_wdata_i;
  logic [N_PORTS-1:0]        s_gnt_o;
  logic [N_PORTS-1:0]        s_rvalid_o;
  logic [N_PORTS*DATA_W-1:0] s_rdata_o;

  logic                      m_req_o;
  logic                      m_we_o;
  logic [BE_W-1:0]           m_be_o;
  logic [ADDR_W-1:0]         m_addr_o;
  logic [DATA_W-1:0]         m_wdata_o;
  logic                      m_gnt_i;
  logic                      m_rvalid_i;
  logic [DATA_W-1:0]         m_rdata_i;

  logic                      inv_req_i;
  logic [ADDR_W-1:0]         inv_addr_i;
  logic                      inv_ack_o;
  logic [N_PORTS-1:0]        inv_req_o;
  logic [ADDR_W-1:0]         inv_addr_o;
  logic [N_PORTS-1:0]        inv_ack_i;

  modport slave (
    input  s_req_i, s_we_i, s_be_i, s_addr_i, s_wdata_i,
    output s_gnt_o, s_rvalid_o, s_rdata_o,
    output m_req_o, m_we_o, m_be_o, m_addr_o, m_wdata_o,
    input  m_gnt_i, m_rvalid_i, m_rdata_i,
    input  inv_req_i, inv_addr_i, inv_ack_i,
    output inv_ack_o, inv_req_o, inv_addr_o
  );

  modport master (
    output s_req_i, s_we_i, s_be_i, s_addr_i, s_wdata_i,
    input  s_gnt_o, s_rvalid_o, s_rdata_o,
    input  m_req_o, m_we_o, m_be_o, m_addr_o, m_wdata_o,
    output m_gnt_i, m_rvalid_i, m_rdata_i,
    output inv_req_i, inv_addr_i, inv_ack_i,
    input  inv_ack_o, inv_req_o, inv_addr_o
  );

endinterface

// File: rtl/cpu64_rr_arbiter.sv
// Combinational round-robin picker: first requester after last_i (wrapping).
module cpu64_rr_arbiter #(
  parameter int unsigned N     = 2,
  parameter int unsigned IDX_W = 1
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] last_i,
  output logic [N-1:0]     gnt_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             valid_o
);

  logic [IDX_W-1:0] cand_s;
  logic             take_s;

  // Walk candidates last+1 .. last+N; the first requester found wins.
  always_comb begin
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    cand_s  = '0;
    take_s  = 1'b0;
    for (int unsigned i = 1; i <= N; i++) begin
      cand_s         = IDX_W'((32'(last_i) + i) % N);
      take_s         = ~valid_o & req_i[cand_s];
      gnt_o[cand_s]  = gnt_o[cand_s] | take_s;
      idx_o          = take_s ? cand_s : idx_o;
      valid_o        = valid_o | take_s;
    end
  end

endmodule

// File: rtl/cpu64_l3_port_arbiter.sv
// Multiplexes N L2 requesters onto a single L3 port with one transaction
// outstanding, and fans L3 back-invalidates out to all L2s.
module cpu64_l3_port_arbiter
  import cpu64_l3_pkg::*;
#(
  parameter int unsigned N_PORTS = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  cpu64_l3_port_arbiter_if.slave bus
);

  localparam int unsigned IDX_W = idx_w(N_PORTS);

  arb_state_e         state_q, state_d;
  inv_state_e         inv_state_q, inv_state_d;
  logic [IDX_W-1:0]   owner_q, owner_d, last_q, last_d;
  logic [N_PORTS-1:0] mask_q, mask_d, acked_q, acked_d;
  logic               we_q, we_d;
  logic [BE_W-1:0]    be_q, be_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d;

  logic [N_PORTS-1:0] win_gnt_s, inv_hit_s;
  logic [IDX_W-1:0]   win_idx_s;
  logic               win_valid_s, busy_s, done_s, all_acked_s, inv_ack_s;
  logic               sel_we_s;
  logic [BE_W-1:0]    sel_be_s;
  logic [ADDR_W-1:0]  sel_addr_s;
  logic [DATA_W-1:0]  sel_wdata_s;

  cpu64_rr_arbiter #(.N(N_PORTS), .IDX_W(IDX_W)) u_rr (
    .req_i   (bus.s_req_i & ~mask_q),
    .last_i  (last_q),
    .gnt_o   (win_gnt_s),
    .idx_o   (win_idx_s),
    .valid_o (win_valid_s)
  );

  // Pick the winner's request fields.
  always_comb begin
    sel_we_s    = 1'b0;
    sel_be_s    = '0;
    sel_addr_s  = '0;
    sel_wdata_s = '0;
    for (int unsigned k = 0; k < N_PORTS; k++) begin
      sel_we_s    = win_gnt_s[k] ? bus.s_we_i[k] : sel_we_s;
      sel_be_s    = win_gnt_s[k] ? bus.s_be_i[k*BE_W +: BE_W] : sel_be_s;
      sel_addr_s  = win_gnt_s[k] ? bus.s_addr_i[k*ADDR_W +: ADDR_W] : sel_addr_s;
      sel_wdata_s = win_gnt_s[k] ? bus.s_wdata_i[k*DATA_W +: DATA_W] : sel_wdata_s;
    end
  end

  assign busy_s = (state_q == ARB_BUSY);
  assign done_s = busy_s & (we_q ? bus.m_gnt_i : bus.m_rvalid_i);

  // Arbiter next state; the finishing owner is masked for one cycle.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    mask_d  = '0;
    we_d    = we_q;
    be_d    = be_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      ARB_IDLE: begin
        if (win_valid_s) begin
          state_d = ARB_BUSY;
          owner_d = win_idx_s;
          we_d    = sel_we_s;
          be_d    = sel_be_s;
          addr_d  = sel_addr_s;
          wdata_d = sel_wdata_s;
        end else begin
          state_d = ARB_IDLE;
        end
      end
      ARB_BUSY: begin
        if (done_s) begin
          state_d         = ARB_IDLE;
          last_d          = owner_q;
          mask_d[owner_q] = 1'b1;
        end else begin
          state_d = ARB_BUSY;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  assign bus.m_req_o   = busy_s & ~done_s;
  assign bus.m_we_o    = busy_s & we_q;
  assign bus.m_be_o    = busy_s ? be_q : '0;
  assign bus.m_addr_o  = busy_s ? addr_q : '0;
  assign bus.m_wdata_o = busy_s ? wdata_q : '0;

  // Route L3 responses straight back to the owner.
  always_comb begin
    bus.s_gnt_o    = '0;
    bus.s_rvalid_o = '0;
    bus.s_rdata_o  = '0;
    for (int unsigned k = 0; k < N_PORTS; k++) begin
      bus.s_gnt_o[k]    = busy_s && (owner_q == IDX_W'(k)) && bus.m_gnt_i;
      bus.s_rvalid_o[k] = busy_s && (owner_q == IDX_W'(k)) && bus.m_rvalid_i;
      bus.s_rdata_o[k*DATA_W +: DATA_W] =
        (busy_s && (owner_q == IDX_W'(k))) ? bus.m_rdata_i : '0;
    end
  end

  assign inv_hit_s   = bus.inv_ack_i & {N_PORTS{bus.inv_req_i}};
  assign all_acked_s = &(acked_q | inv_hit_s);

  // Invalidate collector, independent of data arbitration.
  always_comb begin
    inv_state_d = inv_state_q;
    acked_d     = acked_q;
    inv_ack_s   = 1'b0;
    case (inv_state_q)
      INV_IDLE: begin
        if (bus.inv_req_i) begin
          acked_d = acked_q | inv_hit_s;
          if (all_acked_s) begin
            inv_ack_s   = 1'b1;
            inv_state_d = INV_DONE;
          end else begin
            inv_state_d = INV_IDLE;
          end
        end else begin
          acked_d = '0;
        end
      end
      INV_DONE: begin
        if (!bus.inv_req_i) begin
          inv_state_d = INV_IDLE;
          acked_d     = '0;
        end else begin
          inv_state_d = INV_DONE;
        end
      end
      default: inv_state_d = INV_IDLE;
    endcase
  end

  // Pass-through paths are gated so nothing leaks out while in reset.
  assign bus.inv_req_o  = (rst_ni && (inv_state_q == INV_IDLE)) ?
                          ({N_PORTS{bus.inv_req_i}} & ~acked_q) : '0;
  assign bus.inv_addr_o = rst_ni ? bus.inv_addr_i : '0;
  assign bus.inv_ack_o  = rst_ni & inv_ack_s;

  // State registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ARB_IDLE;
      inv_state_q <= INV_IDLE;
      owner_q     <= '0;
      last_q      <= IDX_W'(N_PORTS - 32'd1);
      mask_q      <= '0;
      acked_q     <= '0;
      we_q        <= 1'b0;
      be_q        <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      inv_state_q <= inv_state_d;
      owner_q     <= owner_d;
      last_q      <= last_d;
      mask_q      <= mask_d;
      acked_q     <= acked_d;
      we_q        <= we_d;
      be_q        <= be_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
    end
  end

endmodule

// File: tb/tb_cpu64_l3_port_arbiter.sv
// Directed bench for cpu64_l3_port_arbiter with two L2 ports: per-cycle
// vector tables plus hand-written long-miss and reset sequences.
module tb_cpu64_l3_port_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  cpu64_l3_port_arbiter_if #(.N_PORTS(2)) bus ();

  cpu64_l3_port_arbiter #(.N_PORTS(2)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  int n_total = 0;
  int n_bad   = 0;

  typedef struct {
    logic [1:0]  req;
    logic [1:0]  we;
    logic        gnt;
    logic        rv;
    logic [63:0] rdata;
    logic        e_mreq;
    logic        e_mwe;
    logic [63:0] e_addr;
    logic [1:0]  e_gnt;
    logic [1:0]  e_rv;
    logic [63:0] e_rd0;
    logic [63:0] e_rd1;
  } arb_vec_t;

  typedef struct {
    logic       inv;
    logic [1:0] ack;
    logic [1:0] req;
    logic [1:0] we;
    logic       gnt;
    logic [1:0] e_ir;
    logic       e_ia;
    logic       e_mreq;
    logic [1:0] e_sgnt;
  } inv_vec_t;

  arb_vec_t av[$];
  inv_vec_t iv[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    bus.s_req_i    = 2'b00;
    bus.s_we_i     = 2'b00;
    bus.m_gnt_i    = 1'b0;
    bus.m_rvalid_i = 1'b0;
    bus.m_rdata_i  = 64'h0;
    bus.inv_req_i  = 1'b0;
    bus.inv_ack_i  = 2'b00;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".m_req"},  64'(bus.m_req_o), 64'h0);
    check({tag, ".m_we"},   64'(bus.m_we_o), 64'h0);
    check({tag, ".m_addr"}, bus.m_addr_o, 64'h0);
    check({tag, ".m_be"},   64'(bus.m_be_o), 64'h0);
    check({tag, ".s_gnt"},  64'(bus.s_gnt_o), 64'h0);
    check({tag, ".s_rv"},   64'(bus.s_rvalid_o), 64'h0);
    check({tag, ".rd0"},    bus.s_rdata_o[63:0], 64'h0);
    check({tag, ".rd1"},    bus.s_rdata_o[127:64], 64'h0);
    check({tag, ".inv_req"}, 64'(bus.inv_req_o), 64'h0);
    check({tag, ".inv_ack"}, 64'(bus.inv_ack_o), 64'h0);
    check({tag, ".inv_addr"}, bus.inv_addr_o, 64'h0);
  endtask

  initial begin
    int hi;
    int gc;
    int rc;

    // req we gnt rv rdata | mreq mwe addr gnt rv rd0 rd1
    av.push_back('{2'b01, 2'b00, 1'b0, 1'b0, 64'h0,  1'b0, 1'b0, 64'h0,    2'b00, 2'b00, 64'h0,  64'h0});
    av.push_back('{2'b01, 2'b00, 1'b0, 1'b0, 64'h0,  1'b1, 1'b0, 64'h1000, 2'b00, 2'b00, 64'h0,  64'h0});
    av.push_back('{2'b01, 2'b00, 1'b1, 1'b1, 64'hAA, 1'b0, 1'b0, 64'h1000, 2'b01, 2'b01, 64'hAA, 64'h0});
    av.push_back('{2'b01, 2'b00, 1'b0, 1'b0, 64'h0,  1'b0, 1'b0, 64'h0,    2'b00, 2'b00, 64'h0,  64'h0});
    av.push_back('{2'b00, 2'b00, 1'b0, 1'b0, 64'h0,  1'b0, 1'b0, 64'h0,    2'b00, 2'b00, 64'h0,  64'h0});
    av.push_back('{2'b11, 2'b00, 1'b0, 1'b0, 64'h0,  1'b0, 1'b0, 64'h0,    2'b00, 2'b00, 64'h0,  64'h0});
    av.push_back('{2'b11, 2'b00, 1'b1, 1'b1, 64'h11, 1'b0, 1'b0, 64'h2000, 2'b10, 2'b10, 64'h0,  64'h11});
    av.push_back('{2'b11, 2'b00, 1'b0, 1'b0, 64'h0,  1'b0, 1'b0, 64'h0,    2'b00, 2'b00, 64'h0,  64'h0});
    av.push_back('{2'b11, 2'b00, 1'b1, 1'b1, 64'h22, 1'b0, 1'b0, 64'h1000, 2'b01, 2'b01, 64'h22, 64'h0});
    av.push_back('{2'b11, 2'b00, 1'b0, 1'b0, 64'h0,  1'b0, 1'b0, 64'h0,    2'b00, 2'b00, 64'h0,  64'h0});
    av.push_back('{2'b11, 2'b00, 1'b1, 1'b1, 64'h33, 1'b0, 1'b0, 64'h2000, 2'b10, 2'b10, 64'h0,  64'h33});
    av.push_back('{2'b00, 2'b00, 1'b0, 1'b0, 64'h0,  1'b0, 1'b0, 64'h0,    2'b00, 2'b00, 64'h0,  64'h0});
    av.push_back('{2'b01, 2'b00, 1'b0, 1'b0, 64'h0,  1'b0, 1'b0, 64'h0,    2'b00, 2'b00, 64'h0,  64'h0});
    av.push_back('{2'b01, 2'b00, 1'b1, 1'b0, 64'h0,  1'b1, 1'b0, 64'h1000, 2'b01, 2'b00, 64'h0,  64'h0});
    av.push_back('{2'b01, 2'b00, 1'b0, 1'b1, 64'h44, 1'b0, 1'b0, 64'h1000, 2'b00, 2'b01, 64'h44, 64'h0});
    av.push_back('{2'b00, 2'b00, 1'b0, 1'b0, 64'h0,  1'b0, 1'b0, 64'h0,    2'b00, 2'b00, 64'h0,  64'h0});
    av.push_back('{2'b10, 2'b10, 1'b0, 1'b0, 64'h0,  1'b0, 1'b0, 64'h0,    2'b00, 2'b00, 64'h0,  64'h0});
    av.push_back('{2'b10, 2'b10, 1'b1, 1'b0, 64'h0,  1'b0, 1'b1, 64'h2000, 2'b10, 2'b00, 64'h0,  64'h0});
    av.push_back('{2'b00, 2'b00, 1'b0, 1'b0, 64'h0,  1'b0, 1'b0, 64'h0,    2'b00, 2'b00, 64'h0,  64'h0});

    // inv ack req we gnt | inv_req_o inv_ack_o m_req s_gnt
    iv.push_back('{1'b1, 2'b00, 2'b00, 2'b00, 1'b0, 2'b11, 1'b0, 1'b0, 2'b00});
    iv.push_back('{1'b1, 2'b00, 2'b01, 2'b01, 1'b0, 2'b11, 1'b0, 1'b0, 2'b00});
    iv.push_back('{1'b1, 2'b01, 2'b01, 2'b01, 1'b0, 2'b11, 1'b0, 1'b1, 2'b00});
    iv.push_back('{1'b1, 2'b00, 2'b01, 2'b01, 1'b1, 2'b10, 1'b0, 1'b0, 2'b01});
    iv.push_back('{1'b1, 2'b00, 2'b00, 2'b00, 1'b0, 2'b10, 1'b0, 1'b0, 2'b00});
    iv.push_back('{1'b1, 2'b10, 2'b00, 2'b00, 1'b0, 2'b10, 1'b1, 1'b0, 2'b00});
    iv.push_back('{1'b1, 2'b00, 2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00});
    iv.push_back('{1'b1, 2'b00, 2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00});
    iv.push_back('{1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00});
    iv.push_back('{1'b1, 2'b11, 2'b00, 2'b00, 1'b0, 2'b11, 1'b1, 1'b0, 2'b00});
    iv.push_back('{1'b1, 2'b00, 2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00});
    iv.push_back('{1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00});
    iv.push_back('{1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00});

    bus.s_addr_i  = {64'h2000, 64'h1000};
    bus.s_wdata_i = {64'hD1, 64'hD0};
    bus.s_be_i    = {8'h0F, 8'hFF};
    bus.inv_addr_i = 64'h20000;

    // Reset with hostile inputs: every output must stay 0.
    rst_n = 1'b0;
    clear_inputs();
    bus.s_req_i    = 2'b11;
    bus.m_gnt_i    = 1'b1;
    bus.m_rvalid_i = 1'b1;
    bus.inv_req_i  = 1'b1;
    bus.inv_ack_i  = 2'b11;
    repeat (2) @(negedge clk);
    #1;
    check_all_zero("rst");
    clear_inputs();
    rst_n = 1'b1;
    @(negedge clk);

    foreach (av[i]) begin
      bus.s_req_i    = av[i].req;
      bus.s_we_i     = av[i].we;
      bus.m_gnt_i    = av[i].gnt;
      bus.m_rvalid_i = av[i].rv;
      bus.m_rdata_i  = av[i].rdata;
      #1;
      check($sformatf("arb%0d.m_req", i), 64'(bus.m_req_o), 64'(av[i].e_mreq));
      check($sformatf("arb%0d.m_we", i), 64'(bus.m_we_o), 64'(av[i].e_mwe));
      check($sformatf("arb%0d.m_addr", i), bus.m_addr_o, av[i].e_addr);
      check($sformatf("arb%0d.s_gnt", i), 64'(bus.s_gnt_o), 64'(av[i].e_gnt));
      check($sformatf("arb%0d.s_rv", i), 64'(bus.s_rvalid_o), 64'(av[i].e_rv));
      check($sformatf("arb%0d.rd0", i), bus.s_rdata_o[63:0], av[i].e_rd0);
      check($sformatf("arb%0d.rd1", i), bus.s_rdata_o[127:64], av[i].e_rd1);
      @(negedge clk);
    end
    clear_inputs();

    // Port 1 write with a 20-cycle L3 miss.
    bus.s_req_i = 2'b10;
    bus.s_we_i  = 2'b10;
    @(negedge clk);
    hi = 0;
    gc = 0;
    rc = 0;
    for (int c = 0; c < 21; c++) begin
      bus.m_gnt_i = (c == 20);
      #1;
      hi += int'(bus.m_req_o);
      gc += int'(bus.s_gnt_o[1]);
      rc += int'(|bus.s_rvalid_o);
      if (c == 0) begin
        check("wr.m_we", 64'(bus.m_we_o), 64'h1);
        check("wr.m_be", 64'(bus.m_be_o), 64'h0F);
        check("wr.m_wdata", bus.m_wdata_o, 64'hD1);
        check("wr.m_addr", bus.m_addr_o, 64'h2000);
      end
      @(negedge clk);
    end
    clear_inputs();
    check("wr.req_cycles", 64'(hi), 64'd20);
    check("wr.gnt_pulses", 64'(gc), 64'd1);
    check("wr.rvalid_pulses", 64'(rc), 64'd0);
    #1;
    check("wr.after_m_req", 64'(bus.m_req_o), 64'h0);
    @(negedge clk);

    // Back-invalidate with a concurrent port 0 write-back.
    foreach (iv[i]) begin
      bus.inv_req_i = iv[i].inv;
      bus.inv_ack_i = iv[i].ack;
      bus.s_req_i   = iv[i].req;
      bus.s_we_i    = iv[i].we;
      bus.m_gnt_i   = iv[i].gnt;
      #1;
      check($sformatf("inv%0d.inv_req", i), 64'(bus.inv_req_o), 64'(iv[i].e_ir));
      check($sformatf("inv%0d.inv_ack", i), 64'(bus.inv_ack_o), 64'(iv[i].e_ia));
      check($sformatf("inv%0d.inv_addr", i), bus.inv_addr_o, 64'h20000);
      check($sformatf("inv%0d.m_req", i), 64'(bus.m_req_o), 64'(iv[i].e_mreq));
      check($sformatf("inv%0d.s_gnt", i), 64'(bus.s_gnt_o), 64'(iv[i].e_sgnt));
      @(negedge clk);
    end
    clear_inputs();

    // Reset in the middle of a port 1 read.
    bus.s_req_i = 2'b10;
    @(negedge clk);
    bus.s_req_i = 2'b00;
    #1;
    check("mid.m_req_before", 64'(bus.m_req_o), 64'h1);
    check("mid.m_addr_before", bus.m_addr_o, 64'h2000);
    bus.m_gnt_i    = 1'b1;
    bus.m_rvalid_i = 1'b1;
    bus.m_rdata_i  = 64'h55;
    bus.inv_req_i  = 1'b1;
    bus.inv_ack_i  = 2'b11;
    rst_n = 1'b0;
    #1;
    check_all_zero("mid");
    @(negedge clk);
    clear_inputs();
    rst_n = 1'b1;
    bus.s_req_i = 2'b11;
    #1;
    check("post.idle_m_req", 64'(bus.m_req_o), 64'h0);
    @(negedge clk);
    bus.s_req_i = 2'b00;
    #1;
    check("post.m_req", 64'(bus.m_req_o), 64'h1);
    check("post.m_addr", bus.m_addr_o, 64'h1000);
    bus.m_rvalid_i = 1'b1;
    bus.m_rdata_i  = 64'h66;
    #1;
    check("post.s_rv", 64'(bus.s_rvalid_o), 64'h1);
    check("post.rd0", bus.s_rdata_o[63:0], 64'h66);
    @(negedge clk);
    clear_inputs();
    #1;
    check("post.done_m_req", 64'(bus.m_req_o), 64'h0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
